regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU result path and the memory-load path.
- Round-robin arbitration with a valid/ready handshake per requester. The grant is registered into the regfile write port.
- Holds a per-register pending scoreboard. The issue stage sets a register's bit when it reserves that register as a destination; the bit clears on commit. The decode stage reads the busy flags for its two source operands to stall.
- Sits between execute/memory and the register file; drives write_enable, write_address and write_data_in.

Parameters:
- DATA_WIDTH, 32, width of writeback data.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of architectural registers (= 2**ADDR_WIDTH).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_address  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU request granted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_address  in  ADDR_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- mem_ready  out  1  load request granted this cycle (combinational).
- reserve_enable  in  1  issue stage reserves a destination register.
- reserve_address  in  ADDR_WIDTH  register being reserved.
- read_address_1  in  ADDR_WIDTH  decode source operand 1.
- read_address_2  in  ADDR_WIDTH  decode source operand 2.
- busy_1  out  1  pending[read_address_1] (combinational).
- busy_2  out  1  pending[read_address_2] (combinational).
- write_enable  out  1  regfile write strobe (registered).
- write_address  out  ADDR_WIDTH  regfile write address (registered).
- write_data_in  out  DATA_WIDTH  regfile write data (registered).
- reserve_error  out  1  sticky: a reservation hit an already-pending register.

Behaviour:
- Reset (async):
  - write_enable=0, write_address=0, write_data_in=0.
  - All pending bits 0; reserve_error=0.
  - Round-robin pointer = MEM, so MEM wins the first contest.
  - Reset mid-transfer discards any granted-but-uncommitted write.
- Handshake:
  - A transfer occurs in the cycle where valid && ready.
  - The requester holds valid, address and data stable until ready.
  - ready never asserts without valid.
- Arbitration:
  - Exactly one valid requester: it is granted.
  - Both valid: the pointer's owner is granted.
  - After every grant the pointer moves to the other requester.
  - No grant leaves the pointer unchanged.
- Latency:
  - Grant in cycle N registers the request onto the write_* outputs at posedge N+1.
  - write_enable is high for one cycle only; the regfile captures the write at posedge N+2.
  - Throughput: one writeback per cycle.
- Register 0:
  - A granted write to address 0 completes the handshake, but write_enable stays 0.
  - Reserving address 0 is ignored and never sets pending or reserve_error.
  - busy for address 0 is always 0.
- Scoreboard:
  - pending[r] sets on a clock edge with reserve_enable and reserve_address=r.
  - pending[r] clears on the edge where write_enable=1 and write_address=r, i.e. at regfile commit.
  - Reserve and clear of the same r on the same edge: pending stays 1 (new reservation wins).
  - Reserving r while pending[r]=1 sets reserve_error; the bit stays 1. reserve_error clears only on reset.
- busy_1 and busy_2 are combinational from current pending. A register whose commit edge is in progress still reads busy in that cycle.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds outputs bypass_hit_1/bypass_hit_2 (1 bit) and bypass_data_1/bypass_data_2 (DATA_WIDTH).
  - bypass_hit_k = write_enable && write_address==read_address_k && read_address_k!=0; bypass_data_k = write_data_in.
  - busy_k is forced 0 when bypass_hit_k, so decode consumes the forwarded value instead of stalling.
- Undefined: these ports are absent and busy is purely pending-based.

Decomposition:
- Shared package regfile_pkg:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants.
  - Requester-id enum {REQ_ALU, REQ_MEM} used for the pointer.
  - ZERO_REG = 0.
- One sub-module, wb_rr_arbiter2: 2-input round-robin grant plus pointer.
- The scoreboard and output register stay in the top level.

Test Plan:
- Reset, then alu_valid only (addr 3, data 0x0000_0038) -> alu_ready same cycle; one cycle later write_enable=1, write_address=3, write_data_in=0x38 for exactly one cycle.
- Both valid for 4 cycles (alu addr 4, mem addr 5) -> grants MEM, ALU, MEM, ALU; write_address sequence 5, 4, 5, 4.
- reserve 7; then ALU writes 7 -> busy for addr 7 is 1 from the edge after reserve through the commit cycle; 0 the cycle after write_enable.
- Reserve 9 on the same edge that 9 commits -> pending[9] remains 1; reserve 9 again -> reserve_error=1 and stays 1 until reset.
- mem writes addr 0 with data 0xFFFF_FFE2 -> mem_ready=1, write_enable stays 0; reserve 0 -> no busy, no error.
- Assert reset while a granted write is in the output register -> write_enable drops immediately; no write follows; all busy outputs 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
// Optional bypass forwarding is enabled with REGFILE_WB_BYPASS_EN (see top).
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered pointer
// naming the requester that wins the next contested cycle.
module wb_rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_grant,
  output logic mem_grant
);

  req_id_e ptr_q;
  req_id_e ptr_d;

  always_comb begin
    alu_grant = alu_valid && (!mem_valid || (ptr_q == REQ_ALU));
    mem_grant = mem_valid && (!alu_valid || (ptr_q == REQ_MEM));
    ptr_d     = ptr_q;
    if (alu_grant) begin
      ptr_d = REQ_MEM;
    end else if (mem_grant) begin
      ptr_d = REQ_ALU;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= REQ_MEM;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load writeback, and keeps a
// per-register pending scoreboard. Define REGFILE_WB_BYPASS_EN for forwarding.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_address,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_address,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data_in,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                  bypass_hit_1,
  output logic                  bypass_hit_2,
  output logic [DATA_WIDTH-1:0] bypass_data_1,
  output logic [DATA_WIDTH-1:0] bypass_data_2,
`endif
  output logic                  reserve_error
);

  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] REG0 = ADDR_WIDTH'(ZERO_REG);

  logic                  alu_grant;
  logic                  mem_grant;

  logic                  write_enable_q,  write_enable_d;
  logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0] write_data_q,    write_data_d;
  logic [NUM_REGS-1:0]   pending_q,       pending_d;
  logic                  reserve_error_q, reserve_error_d;

  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;
  logic                  reserve_live;
  logic                  pend_rd_1;
  logic                  pend_rd_2;

  wb_rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_grant (alu_grant),
    .mem_grant (mem_grant)
  );

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // Writes to register 0 still consume their grant but never strobe the regfile.
  always_comb begin
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    if (alu_grant) begin
      write_enable_d  = (alu_address != REG0);
      write_address_d = alu_address;
      write_data_d    = alu_data;
    end else if (mem_grant) begin
      write_enable_d  = (mem_address != REG0);
      write_address_d = mem_address;
      write_data_d    = mem_data;
    end
  end

  assign reserve_live = reserve_enable && (reserve_address != REG0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      assign set_vec[gi] = reserve_live && (reserve_address == ADDR_WIDTH'(gi));
      assign clr_vec[gi] = write_enable_q && (write_address_q == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Set dominates clear so a fresh reservation on the commit edge survives.
  always_comb begin
    pending_d       = set_vec | (pending_q & ~clr_vec);
    reserve_error_d = reserve_error_q | (reserve_live && pending_q[reserve_address]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      pending_q       <= '0;
      reserve_error_q <= 1'b0;
    end else begin
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      pending_q       <= pending_d;
      reserve_error_q <= reserve_error_d;
    end
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data_in = write_data_q;
  assign reserve_error = reserve_error_q;

  assign pend_rd_1 = pending_q[read_address_1] && (read_address_1 != REG0);
  assign pend_rd_2 = pending_q[read_address_2] && (read_address_2 != REG0);

`ifdef REGFILE_WB_BYPASS_EN
  assign bypass_hit_1  = write_enable_q && (write_address_q == read_address_1) &&
                         (read_address_1 != REG0);
  assign bypass_hit_2  = write_enable_q && (write_address_q == read_address_2) &&
                         (read_address_2 != REG0);
  assign bypass_data_1 = write_data_q;
  assign bypass_data_2 = write_data_q;
  assign busy_1        = pend_rd_1 && !bypass_hit_1;
  assign busy_2        = pend_rd_2 && !bypass_hit_2;
`else
  assign busy_1        = pend_rd_1;
  assign busy_2        = pend_rd_2;
`endif

endmodule
